// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO completer: register offsets, FSM encoding,
// wait-state counter width.
package apb_gpio_pkg;

    localparam logic [7:0] OFS_DATA_OUT = 8'h00;
    localparam logic [7:0] OFS_DIR      = 8'h04;
    localparam logic [7:0] OFS_DATA_IN  = 8'h08;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFS_IRQ_POL  = 8'h10;
    localparam logic [7:0] OFS_IRQ_STAT = 8'h14;
    localparam logic [7:0] OFS_END      = 8'h18;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    function automatic logic ofs_mapped(input logic [7:0] ofs);
        return ofs < OFS_END;
    endfunction

endpackage

// File: rtl/apb_gpio_if.sv
// APB3 bus bundle between the bridge (master) and one GPIO completer (slave).
interface apb_gpio_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser followed by a previous-value flop; emits
// single-cycle rise/fall strobes on the synchronised bus.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Everything clears together so a low pin produces no edge out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 GPIO completer: programmable wait states, output/direction registers,
// synchronised inputs and edge-triggered, maskable interrupts.
//
//  state     | meaning
//  ST_IDLE   | no transfer in progress; waiting for a setup phase
//  ST_ACCESS | access phase; wait counter runs down, PREADY at zero
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int                IO_NUM      = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [IO_NUM-1:0] OUT_RESET   = '0
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    apb_gpio_if.slave         apb_io,
    input  logic [IO_NUM-1:0] gpio_in_i,
    output logic [IO_NUM-1:0] gpio_out_o,
    output logic [IO_NUM-1:0] gpio_oe_o,
    output logic              int_o
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    logic [IO_NUM-1:0] data_out_q, data_out_d;
    logic [IO_NUM-1:0] dir_q, dir_d;
    logic [IO_NUM-1:0] irq_en_q, irq_en_d;
    logic [IO_NUM-1:0] irq_pol_q, irq_pol_d;
    logic [IO_NUM-1:0] irq_stat_q, irq_stat_d;

    logic [IO_NUM-1:0] pin_sync, pin_rise, pin_fall, edge_hit, wdata_io, rd_io;
    logic [7:0]        addr_ofs;
    logic              acc_err, wr_en;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign addr_ofs    = {apb_io.paddr[7:2], 2'b00};
    assign wdata_io    = apb_io.pwdata[IO_NUM-1:0];
    assign unused_bits = ^{apb_io.paddr[1:0], apb_io.pwdata};

    gpio_sync_edge #(.WIDTH(IO_NUM)) u_sync (
        .clk_i  (pclk_i),
        .rst_i  (preset_i),
        .pin_i  (gpio_in_i),
        .sync_o (pin_sync),
        .rise_o (pin_rise),
        .fall_o (pin_fall)
    );

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (apb_io.psel && !apb_io.penable) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                // A deselect mid-access is a protocol violation: abandon quietly.
                if (!apb_io.psel) begin
                    state_d = ST_IDLE;
                end else if (apb_io.penable) begin
                    if (cnt_q != '0) cnt_d   = cnt_q - WAIT_CNT_W'(1);
                    else             state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        apb_io.pready = (state_q == ST_ACCESS) && apb_io.psel && apb_io.penable && (cnt_q == '0);
        acc_err       = !ofs_mapped(addr_ofs) || (apb_io.pwrite && addr_ofs == OFS_DATA_IN);
        apb_io.pslverr = apb_io.pready && acc_err;
        wr_en         = apb_io.pready && apb_io.pwrite && !acc_err;
        apb_io.prdata = (apb_io.pready && !apb_io.pwrite && !acc_err) ? rd_word : 32'h0;
    end

    always_comb begin
        rd_io = '0;
        case (addr_ofs)
            OFS_DATA_OUT: rd_io = data_out_q;
            OFS_DIR:      rd_io = dir_q;
            OFS_DATA_IN:  rd_io = pin_sync;
            OFS_IRQ_EN:   rd_io = irq_en_q;
            OFS_IRQ_POL:  rd_io = irq_pol_q;
            OFS_IRQ_STAT: rd_io = irq_stat_q;
            default:      rd_io = '0;
        endcase
        rd_word             = '0;
        rd_word[IO_NUM-1:0] = rd_io;
    end

    assign edge_hit = (pin_rise & ~irq_pol_q) | (pin_fall & irq_pol_q);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_pol_d  = irq_pol_q;
        irq_stat_d = irq_stat_q;
        if (wr_en) begin
            case (addr_ofs)
                OFS_DATA_OUT: data_out_d = wdata_io;
                OFS_DIR:      dir_d      = wdata_io;
                OFS_IRQ_EN:   irq_en_d   = wdata_io;
                OFS_IRQ_POL:  irq_pol_d  = wdata_io;
                OFS_IRQ_STAT: irq_stat_d = irq_stat_q & ~wdata_io;
                default:      ;
            endcase
        end
        // New edges are applied after the clear so a coincident edge survives.
        irq_stat_d = irq_stat_d | edge_hit;
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            data_out_q <= OUT_RESET;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_pol_q  <= '0;
            irq_stat_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_pol_q  <= irq_pol_d;
            irq_stat_q <= irq_stat_d;
        end
    end

    assign gpio_out_o = data_out_q;
    assign gpio_oe_o  = dir_q;
    assign int_o      = |(irq_stat_q & irq_en_q);
endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: three instances (0, 2 and 3 wait states)
// share one APB driver; a queue holds each transfer's expected response.
module tb_apb_gpio_slave;
    import apb_gpio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        preset;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [7:0]  gpio_in;
    int          dsel;

    apb_gpio_if bus0 ();
    apb_gpio_if bus1 ();
    apb_gpio_if bus2 ();

    assign bus0.psel = psel && (dsel == 0);
    assign bus1.psel = psel && (dsel == 1);
    assign bus2.psel = psel && (dsel == 2);
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus2.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus1.pwrite = pwrite;
    assign bus2.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus1.paddr = paddr;
    assign bus2.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus1.pwdata = pwdata;
    assign bus2.pwdata = pwdata;

    logic [7:0] gout0, gout1, gout2, goe0, goe1, goe2;
    logic       irq0, irq1, irq2;

    apb_gpio_slave #(.IO_NUM(8), .WAIT_STATES(0), .OUT_RESET(8'h00)) u_dut0 (
        .pclk_i(clk), .preset_i(preset), .apb_io(bus0), .gpio_in_i(gpio_in),
        .gpio_out_o(gout0), .gpio_oe_o(goe0), .int_o(irq0));
    apb_gpio_slave #(.IO_NUM(8), .WAIT_STATES(2), .OUT_RESET(8'h00)) u_dut1 (
        .pclk_i(clk), .preset_i(preset), .apb_io(bus1), .gpio_in_i(gpio_in),
        .gpio_out_o(gout1), .gpio_oe_o(goe1), .int_o(irq1));
    apb_gpio_slave #(.IO_NUM(8), .WAIT_STATES(3), .OUT_RESET(8'h3C)) u_dut2 (
        .pclk_i(clk), .preset_i(preset), .apb_io(bus2), .gpio_in_i(gpio_in),
        .gpio_out_o(gout2), .gpio_oe_o(goe2), .int_o(irq2));

    logic [31:0] prdata_m;
    logic        pready_m, pslverr_m;

    always_comb begin
        prdata_m  = bus0.prdata;
        pready_m  = bus0.pready;
        pslverr_m = bus0.pslverr;
        if (dsel == 1) begin
            prdata_m  = bus1.prdata;
            pready_m  = bus1.pready;
            pslverr_m = bus1.pslverr;
        end else if (dsel == 2) begin
            prdata_m  = bus2.prdata;
            pready_m  = bus2.pready;
            pslverr_m = bus2.pslverr;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   ws_tab[3] = '{0, 2, 3};
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives setup then access; returns at the sample point of the PREADY cycle,
    // so a following xfer call forms a back-to-back transfer.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        bit   done;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        e.rdata = wr ? 32'h0 : exp_rd;
        e.err   = exp_err;
        e.waits = ws_tab[dsel];
        sb.push_back(e);
        @(negedge clk);
        penable = 1'b1;
        #1;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            if (pready_m) begin
                done = 1'b1;
            end else begin
                check("wait_prdata", prdata_m, 32'h0);
                check("wait_pslverr", 32'(pslverr_m), 32'h0);
                n++;
                @(negedge clk);
                #1;
            end
        end
        e = sb.pop_front();
        check("xfer_done", 32'(done), 32'h1);
        if (done) begin
            check("prdata", prdata_m, e.rdata);
            check("pslverr", 32'(pslverr_m), 32'(e.err));
            check("waits", n, e.waits);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; gpio_in = 8'h0; dsel = 0;
        repeat (3) @(negedge clk);
        check("rst_gout0", 32'(gout0), 32'h00);
        check("rst_goe0", 32'(goe0), 32'h00);
        check("rst_int0", 32'(irq0), 32'h0);
        check("rst_gout2", 32'(gout2), 32'h3C);
        check("rst_pready", 32'(pready_m), 32'h0);
        preset = 1'b0;

        // Zero wait states: write data/dir, outputs follow the cycle after commit.
        xfer(1'b1, 8'h00, 32'h0000_00A5, 32'h0, 1'b0);
        check("gout0_pre_commit", 32'(gout0), 32'h00);
        bus_idle();
        check("gout0_a5", 32'(gout0), 32'hA5);
        xfer(1'b1, 8'h04, 32'h0000_00FF, 32'h0, 1'b0);
        bus_idle();
        check("goe0_ff", 32'(goe0), 32'hFF);
        xfer(1'b0, 8'h00, 32'h0, 32'hA5, 1'b0);
        xfer(1'b0, 8'h04, 32'h0, 32'hFF, 1'b0);
        xfer(1'b1, 8'h00, 32'hFFFF_FF5A, 32'h0, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 32'h5A, 1'b0);
        xfer(1'b0, 8'h07, 32'h0, 32'hFF, 1'b0);
        bus_idle();

        // Two wait states.
        dsel = 1;
        xfer(1'b1, 8'h00, 32'h0000_00A5, 32'h0, 1'b0);
        bus_idle();
        xfer(1'b0, 8'h00, 32'h0, 32'hA5, 1'b0);
        bus_idle();
        check("gout1_a5", 32'(gout1), 32'hA5);

        // Rising edge on pin 3 with IRQ_EN[3].
        dsel = 0;
        xfer(1'b1, 8'h0C, 32'h08, 32'h0, 1'b0);
        bus_idle();
        gpio_in[3] = 1'b1;
        @(negedge clk);
        check("int_edge1", 32'(irq0), 32'h0);
        @(negedge clk);
        check("int_edge2", 32'(irq0), 32'h0);
        @(negedge clk);
        check("int_edge3", 32'(irq0), 32'h1);
        xfer(1'b0, 8'h14, 32'h0, 32'h08, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 32'h08, 1'b0);
        xfer(1'b1, 8'h14, 32'h08, 32'h0, 1'b0);
        bus_idle();
        check("int_w1c", 32'(irq0), 32'h0);

        // Falling polarity; edge lands on the same clock as the W1C commit.
        xfer(1'b1, 8'h10, 32'h08, 32'h0, 1'b0);
        bus_idle();
        gpio_in[3] = 1'b0;
        xfer(1'b1, 8'h14, 32'h08, 32'h0, 1'b0);
        bus_idle();
        check("int_set_wins", 32'(irq0), 32'h1);
        xfer(1'b0, 8'h14, 32'h0, 32'h08, 1'b0);

        // Error responses leave registers alone.
        xfer(1'b0, 8'h20, 32'h0, 32'h0, 1'b1);
        xfer(1'b1, 8'h08, 32'hFF, 32'h0, 1'b1);
        xfer(1'b0, 8'h08, 32'h0, 32'h00, 1'b0);
        xfer(1'b1, 8'h18, 32'h33, 32'h0, 1'b1);
        xfer(1'b0, 8'h18, 32'h0, 32'h0, 1'b1);
        xfer(1'b0, 8'h00, 32'h0, 32'h5A, 1'b0);
        bus_idle();
        check("gout0_kept", 32'(gout0), 32'h5A);

        // Three wait states: load state, then reset mid-access.
        dsel = 2;
        xfer(1'b1, 8'h00, 32'h11, 32'h0, 1'b0);
        xfer(1'b1, 8'h04, 32'h0F, 32'h0, 1'b0);
        xfer(1'b1, 8'h0C, 32'h01, 32'h0, 1'b0);
        bus_idle();
        check("gout2_11", 32'(gout2), 32'h11);
        check("goe2_0f", 32'(goe2), 32'h0F);
        gpio_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("int2_set", 32'(irq2), 32'h1);
        gpio_in[0] = 1'b0;
        repeat (4) @(negedge clk);

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h77;
        @(negedge clk);
        penable = 1'b1;
        #1 check("rst_acc1_pready", 32'(pready_m), 32'h0);
        @(negedge clk);
        preset = 1'b1;
        #1 check("rst_acc2_pready", 32'(pready_m), 32'h0);
        @(negedge clk);
        preset = 1'b0;
        #1;
        check("post_rst_pready", 32'(pready_m), 32'h0);
        check("post_rst_pslverr", 32'(pslverr_m), 32'h0);
        check("post_rst_prdata", prdata_m, 32'h0);
        check("post_rst_gout2", 32'(gout2), 32'h3C);
        check("post_rst_goe2", 32'(goe2), 32'h00);
        check("post_rst_int2", 32'(irq2), 32'h0);
        check("post_rst_int0", 32'(irq0), 32'h0);
        bus_idle();
        check("no_commit_gout2", 32'(gout2), 32'h3C);
        xfer(1'b1, 8'h00, 32'h66, 32'h0, 1'b0);
        bus_idle();
        check("fresh_gout2", 32'(gout2), 32'h66);
        xfer(1'b0, 8'h04, 32'h0, 32'h00, 1'b0);
        xfer(1'b0, 8'h14, 32'h0, 32'h00, 1'b0);
        bus_idle();
        check("sb_empty", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
